// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with an optional de Bruijn extension.
// The register shifts toward the LSB, and feedback enters at the MSB.
// MODE=0 gives the maximal-length sequence (2^W-1). An all-zero state is recovered
// with a LOCKUP pulse. MODE=1 splices the zero state in after 00..01, which gives
// period 2^W. WRAP pulses when a step lands back on the last loaded (or reset) seed.
module lfsr_gen #(
    parameter int unsigned    W          = 8,
    parameter logic [W-1:0]   TAPS       = 'h1D,
    parameter logic [W-1:0]   RESET_SEED = 'h80
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [W-1:0] SEED,
    input  logic         MODE,
    output logic [W-1:0] Q,
    output logic         SOUT,
    output logic         WRAP,
    output logic         LOCKUP
);

    // Elaboration-time sanity on the parameter set.
    if (W < 2 || W > 32) begin : gen_bad_width
        $error("lfsr_gen: W must be in 2..32");
    end
    if (TAPS[0] != 1'b1) begin : gen_bad_taps
        $error("lfsr_gen: TAPS bit 0 must be set");
    end

    // State that the MODE=0 lock-up escape jumps to.
    localparam logic [W-1:0] MsbOne = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] q_q, q_d;
    logic [W-1:0] seed_q, seed_d;
    logic         wrap_q, wrap_d;
    logic         lockup_q, lockup_d;

    logic         fb;
    logic         fb_n;
    logic         upper_zero;
    logic         state_zero;
    logic         step_lock;
    logic [W-1:0] step_val;

    // Compute the single-step successor of the current state under the active MODE.
    always_comb begin
        fb         = ^(q_q & TAPS);
        upper_zero = ~|q_q[W-1:1];
        state_zero = (q_q == '0);
        // De Bruijn: flipping fb when only bit 0 may be set swaps 00..01 -> 10..0
        // for 00..01 -> 00..0 -> 10..0, so the zero state joins the cycle.
        fb_n       = MODE ? (fb ^ upper_zero) : fb;
        step_lock  = ~MODE & state_zero;
        if (step_lock) begin
            step_val = MsbOne;
        end else begin
            step_val = {fb_n, q_q[W-1:1]};
        end
    end

    // Next-state selection: LOAD beats EN, and EN beats hold. Pulses clear when not stepping.
    always_comb begin
        q_d      = q_q;
        seed_d   = seed_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (LOAD) begin
            q_d    = SEED;
            seed_d = SEED;
        end else if (EN) begin
            q_d      = step_val;
            wrap_d   = (step_val == seed_q);
            lockup_d = step_lock;
        end
    end

    // State and pulse registers, asynchronously reset to the reset seed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q      <= RESET_SEED;
            seed_q   <= RESET_SEED;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    // Registered outputs drive the ports directly.
    always_comb begin
        Q      = q_q;
        SOUT   = q_q[0];
        WRAP   = wrap_q;
        LOCKUP = lockup_q;
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a hand-computed vector table on a 3-bit
// instance, plus directed sequences on the default 8-bit instance.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       en3, load3, mode3;
    logic [2:0] seed3, q3;
    logic       sout3, wrap3, lock3;

    logic       en8, load8, mode8;
    logic [7:0] seed8, q8;
    logic       sout8, wrap8, lock8;

    lfsr_gen #(.W(3), .TAPS(3'b011), .RESET_SEED(3'b100)) u_dut3 (
        .CLK(clk), .RESET(rst), .EN(en3), .LOAD(load3), .SEED(seed3), .MODE(mode3),
        .Q(q3), .SOUT(sout3), .WRAP(wrap3), .LOCKUP(lock3)
    );

    lfsr_gen u_dut8 (
        .CLK(clk), .RESET(rst), .EN(en8), .LOAD(load8), .SEED(seed8), .MODE(mode8),
        .Q(q8), .SOUT(sout8), .WRAP(wrap8), .LOCKUP(lock8)
    );

    typedef struct {
        logic       load;
        logic       en;
        logic       mode;
        logic [2:0] seed;
        logic [2:0] q;
        logic       wrap;
        logic       lock;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic ld, input logic e, input logic m, input logic [2:0] s,
                       input logic [2:0] eq, input logic ew, input logic el);
        vec_t v;
        v.load = ld; v.en = e; v.mode = m; v.seed = s;
        v.q = eq; v.wrap = ew; v.lock = el;
        vecs.push_back(v);
    endtask

    // Free-run from reset until the first WRAP, then check the period length and that
    // every state is distinct.
    task automatic run_period(input logic m, input int exp_len, input string tag);
        logic [255:0] seen;
        int steps = 0, dups = 0, locks = 0;
        bit got = 0;
        rst = 1'b1; en8 = 1'b0; load8 = 1'b0; mode8 = m;
        @(negedge clk);
        check({tag, "_reset_q"}, q8, 8'h80);
        rst = 1'b0; en8 = 1'b1;
        seen = '0;
        seen[8'h80] = 1'b1;
        while (!got && steps < 600) begin
            @(negedge clk);
            steps++;
            if (lock8) locks++;
            if (wrap8) got = 1;
            else begin
                if (seen[q8]) dups++;
                seen[q8] = 1'b1;
            end
        end
        check({tag, "_wrap_seen"}, 32'(got), 32'd1);
        check({tag, "_period"}, steps, exp_len);
        check({tag, "_wrap_q"}, q8, 8'h80);
        check({tag, "_distinct"}, $countones(seen), exp_len);
        check({tag, "_dups"}, dups, 0);
        check({tag, "_lockups"}, locks, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        en3 = 1'b1; load3 = 1'b0; mode3 = 1'b1; seed3 = '0;
        en8 = 1'b0; load8 = 1'b0; mode8 = 1'b0; seed8 = '0;

        // 3-bit de Bruijn run from reset: 100 -> ... -> 000 -> 100
        add(0, 1, 1, 3'b000, 3'b010, 0, 0);
        add(0, 1, 1, 3'b000, 3'b101, 0, 0);
        add(0, 1, 1, 3'b000, 3'b110, 0, 0);
        add(0, 1, 1, 3'b000, 3'b111, 0, 0);
        add(0, 1, 1, 3'b000, 3'b011, 0, 0);
        add(0, 1, 1, 3'b000, 3'b001, 0, 0);
        add(0, 1, 1, 3'b000, 3'b000, 0, 0);
        add(0, 1, 1, 3'b000, 3'b100, 1, 0);
        add(0, 1, 1, 3'b000, 3'b010, 0, 0);
        // hold
        add(0, 0, 1, 3'b000, 3'b010, 0, 0);
        add(0, 0, 0, 3'b000, 3'b010, 0, 0);
        // maximal-length run, period 7
        add(1, 1, 0, 3'b100, 3'b100, 0, 0);
        add(0, 1, 0, 3'b000, 3'b010, 0, 0);
        add(0, 1, 0, 3'b000, 3'b101, 0, 0);
        add(0, 1, 0, 3'b000, 3'b110, 0, 0);
        add(0, 1, 0, 3'b000, 3'b111, 0, 0);
        add(0, 1, 0, 3'b000, 3'b011, 0, 0);
        add(0, 1, 0, 3'b000, 3'b001, 0, 0);
        add(0, 1, 0, 3'b000, 3'b100, 1, 0);
        // zero seed in MODE=0 -> lock-up escape
        add(1, 0, 0, 3'b000, 3'b000, 0, 0);
        add(0, 1, 0, 3'b000, 3'b100, 0, 1);
        add(0, 1, 0, 3'b000, 3'b010, 0, 0);
        // mode switch mid-run: 001 -(m1)-> 000 -(m0)-> 100 with LOCKUP
        add(1, 0, 1, 3'b001, 3'b001, 0, 0);
        add(0, 1, 1, 3'b000, 3'b000, 0, 0);
        add(0, 1, 0, 3'b000, 3'b100, 0, 1);
        add(0, 1, 0, 3'b000, 3'b010, 0, 0);
        add(0, 1, 0, 3'b000, 3'b101, 0, 0);
        add(0, 1, 0, 3'b000, 3'b110, 0, 0);
        add(0, 1, 0, 3'b000, 3'b111, 0, 0);
        add(0, 1, 0, 3'b000, 3'b011, 0, 0);
        add(0, 1, 0, 3'b000, 3'b001, 1, 0);
        // zero seed in MODE=1 -> normal step, no lock-up
        add(1, 0, 1, 3'b000, 3'b000, 0, 0);
        add(0, 1, 1, 3'b000, 3'b100, 0, 0);

        // Reset state, held across an edge with EN=1.
        #2 rst = 1'b1;
        #1;
        check("rst_async_q3", q3, 3'b100);
        check("rst_async_q8", q8, 8'h80);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_q3", q3, 3'b100);
        check("rst_wrap3", wrap3, 1'b0);
        check("rst_lock3", lock3, 1'b0);
        check("rst_sout3", sout3, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            load3 = vecs[i].load; en3 = vecs[i].en;
            mode3 = vecs[i].mode; seed3 = vecs[i].seed;
            @(negedge clk);
            check($sformatf("v%0d_q", i), q3, vecs[i].q);
            check($sformatf("v%0d_sout", i), sout3, vecs[i].q[0]);
            check($sformatf("v%0d_wrap", i), wrap3, vecs[i].wrap);
            check($sformatf("v%0d_lock", i), lock3, vecs[i].lock);
        end
        en3 = 1'b0; load3 = 1'b0;

        // 8-bit zero seed, MODE=0.
        load8 = 1'b1; seed8 = 8'h00; mode8 = 1'b0;
        @(negedge clk);
        check("z_q", q8, 8'h00);
        check("z_lock", lock8, 1'b0);
        load8 = 1'b0; en8 = 1'b1;
        @(negedge clk);
        check("z_escape_q", q8, 8'h80);
        check("z_escape_lock", lock8, 1'b1);
        check("z_escape_wrap", wrap8, 1'b0);
        @(negedge clk);
        check("z_next_q", q8, 8'h40);
        check("z_next_lock", lock8, 1'b0);

        // Random EN, then LOAD and EN together: load wins, no step.
        repeat (20) begin
            en8 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        load8 = 1'b1; en8 = 1'b1; seed8 = 8'h5A;
        @(negedge clk);
        check("ld_q", q8, 8'h5A);
        check("ld_wrap", wrap8, 1'b0);
        load8 = 1'b0; en8 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("hold_q", q8, 8'h5A);
            check("hold_wrap", wrap8, 1'b0);
        end
        en8 = 1'b1;
        @(negedge clk);
        check("ld_step_q", q8, 8'h2D);

        // Full-period runs from reset.
        run_period(1'b0, 255, "p_m0");
        run_period(1'b1, 256, "p_m1");

        // Asynchronous reset between edges mid-run.
        mode8 = 1'b0; en8 = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_q", q8, 8'h80);
        check("arst_wrap", wrap8, 1'b0);
        check("arst_lock", lock8, 1'b0);
        @(negedge clk);
        check("arst_hold_q", q8, 8'h80);
        rst = 1'b0;
        @(negedge clk);
        check("arst_restart_q", q8, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
